// File: rtl/mmio_bus_decoder.sv
// mmio_bus_decoder: splits the core load/store port between data memory and
// N_PERIPH memory-mapped peripheral slots. Misses pass through combinationally;
// hits run a three-state handshake (IDLE -> WAIT -> RESP) that stalls the core
// until the addressed slot acknowledges.
// Optional build macro MMIO_TIMEOUT_EN adds a WAIT-cycle watchdog that ends a
// hung access with ERR_DATA and logs a sticky bus error with its address.
module mmio_bus_decoder #(
    parameter logic [31:0] BASE_ADDR = 32'd60,
    parameter int          N_PERIPH  = 4,
    parameter int          WINDOW    = 4,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF,
    localparam int         OFF_W     = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_write,
    input  logic                  mem_read,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  stall,
    output logic                  wem,
    input  logic [31:0]           dmem_rdata,
    output logic [N_PERIPH-1:0]   per_sel,
    output logic                  per_we,
    output logic                  per_re,
    output logic [OFF_W-1:0]      per_off,
    output logic [31:0]           per_wdata,
    input  logic [32*N_PERIPH-1:0] per_rdata,
    input  logic [N_PERIPH-1:0]   per_ready,
    input  logic                  err_clr,
    output logic                  bus_err,
    output logic [31:0]           err_addr
);

    localparam int          SLOT_W = (N_PERIPH > 1) ? $clog2(N_PERIPH) : 1;
    localparam int          SHIFT  = $clog2(WINDOW);
    // Region bounds carried at 33 bits so BASE_ADDR near the top cannot wrap.
    localparam logic [32:0] LO     = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI     = LO + 33'(N_PERIPH * WINDOW);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic                req;
    logic                hit;
    logic                start;
    logic [SLOT_W-1:0]   slot_in;
    logic [OFF_W-1:0]    off_in;
    logic [SLOT_W-1:0]   slot_q;
    logic [OFF_W-1:0]    off_q;
    logic                we_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                ready_sel;
    logic [31:0]         rdata_sel;
    logic                timeout;

    assign req     = mem_write | mem_read;
    assign hit     = ({1'b0, addr} >= LO) && ({1'b0, addr} < HI);
    assign start   = (state_q == IDLE) && req && hit;
    assign slot_in = SLOT_W'((addr - BASE_ADDR) >> SHIFT);
    assign off_in  = OFF_W'(addr % 32'(WINDOW));

    // Data memory only sees stores that fall outside the peripheral window.
    assign wem = mem_write & ~hit;

    // Route the latched slot's ready bit and read-data slice; other slots are ignored.
    always_comb begin
        ready_sel = 1'b0;
        rdata_sel = '0;
        for (int k = 0; k < N_PERIPH; k++) begin
            if (slot_q == SLOT_W'(k)) begin
                ready_sel = per_ready[k];
                rdata_sel = per_rdata[32*k +: 32];
            end
        end
    end

`ifdef MMIO_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic             bus_err_q;
    logic [31:0]      err_addr_q;

    // Ready has priority: a timeout only fires on the last WAIT cycle without ready.
    assign timeout = (state_q == WAIT) && !ready_sel && (cnt_q == CNT_W'(TIMEOUT - 1));

    // WAIT-cycle counter and access address, both captured when an access starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            addr_q <= '0;
        end else if (start) begin
            cnt_q  <= '0;
            addr_q <= addr;
        end else if (state_q == WAIT) begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    // Sticky error flag; a new error in the same cycle as err_clr wins and re-logs its address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else if (timeout) begin
            bus_err_q <= 1'b1;
            if (!bus_err_q || err_clr) begin
                err_addr_q <= addr_q;
            end
        end else if (err_clr) begin
            bus_err_q <= 1'b0;
        end
    end

    assign bus_err  = bus_err_q;
    assign err_addr = err_addr_q;
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign bus_err    = 1'b0;
    assign err_addr   = '0;
    assign unused_cfg = err_clr ^ (^32'(TIMEOUT));
`endif

    // FSM state register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and core/peripheral-facing outputs.
    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        per_sel   = '0;
        per_we    = 1'b0;
        per_re    = 1'b0;
        per_off   = '0;
        per_wdata = '0;
        rdata     = dmem_rdata;
        case (state_q)
            IDLE: begin
                // Gated by rst_n so a held request cannot stall the core during reset.
                stall = rst_n & req & hit;
                if (req && hit) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                stall     = 1'b1;
                per_sel   = N_PERIPH'(1) << slot_q;
                per_we    = we_q;
                per_re    = ~we_q;
                per_off   = off_q;
                per_wdata = wdata_q;
                if (ready_sel || timeout) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rdata   = rdata_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Access latches on entry to WAIT; read data captured on ready or replaced on timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q  <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (start) begin
                slot_q  <= slot_in;
                off_q   <= off_in;
                we_q    <= mem_write;
                wdata_q <= wdata;
            end
            if (state_q == WAIT) begin
                if (ready_sel) begin
                    if (!we_q) begin
                        rdata_q <= rdata_sel;
                    end
                end else if (timeout) begin
                    rdata_q <= ERR_DATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_mmio_bus_decoder.sv
// Scoreboard bench for mmio_bus_decoder: the driver pushes the expected
// response of each access, a negedge monitor checks stall cycles and the
// accepting cycle against the queue head.
module tb_mmio_bus_decoder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mem_write = 1'b0;
    logic         mem_read = 1'b0;
    logic [31:0]  addr = '0;
    logic [31:0]  wdata = '0;
    logic [31:0]  rdata;
    logic         stall;
    logic         wem;
    logic [31:0]  dmem_rdata = '0;
    logic [3:0]   per_sel;
    logic         per_we;
    logic         per_re;
    logic [1:0]   per_off;
    logic [31:0]  per_wdata;
    logic [127:0] per_rdata = {32'h4444_4444, 32'h3333_3333, 32'h0000_00A5, 32'h1111_1111};
    logic [3:0]   per_ready = '0;
    logic         err_clr = 1'b0;
    logic         bus_err;
    logic [31:0]  err_addr;

    mmio_bus_decoder #(
        .BASE_ADDR(32'd60), .N_PERIPH(4), .WINDOW(4), .TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mem_write(mem_write), .mem_read(mem_read),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .wem(wem),
        .dmem_rdata(dmem_rdata), .per_sel(per_sel), .per_we(per_we), .per_re(per_re),
        .per_off(per_off), .per_wdata(per_wdata), .per_rdata(per_rdata),
        .per_ready(per_ready), .err_clr(err_clr), .bus_err(bus_err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        is_read;
        logic [31:0] rd;
        logic        wem;
        int          stalls;
        logic [3:0]  sel;
        logic        we;
        logic        re;
        logic [1:0]  off;
        logic [31:0] wd;
        logic        chk_err;
        logic        be;
        logic [31:0] ea;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(string name, logic is_read, logic [31:0] rd, logic wem_e,
                                int stalls, logic [3:0] sel, logic we, logic re, logic [1:0] off,
                                logic [31:0] wd, logic chk_err, logic be, logic [31:0] ea);
        exp_t e;
        e.name = name; e.is_read = is_read; e.rd = rd; e.wem = wem_e; e.stalls = stalls;
        e.sel = sel; e.we = we; e.re = re; e.off = off; e.wd = wd;
        e.chk_err = chk_err; e.be = be; e.ea = ea;
        return e;
    endfunction

    // Peripheral model: ready after ready_at WAIT cycles (0 = tied high, -1 = never).
    int ready_at = 0;
    int ready_slot = 0;
    bit noise = 1'b0;
    int wcnt = 0;
    always @(posedge clk) begin
        #2;
        if (per_sel != 4'b0) wcnt++;
        else wcnt = 0;
        per_ready = '0;
        if (noise && per_sel != 4'b0) per_ready[0] = wcnt[0];
        if (ready_at == 0) per_ready[ready_slot] = 1'b1;
        else if (ready_at > 0 && wcnt >= ready_at) per_ready[ready_slot] = 1'b1;
    end

    // Monitor: stall cycles checked against the head; accept cycle pops and compares.
    int   stall_cnt = 0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_cnt = 0;
        end else if ((mem_read || mem_write) && sb.size() > 0) begin
            mon_e = sb[0];
            if (stall) begin
                chk({mon_e.name, " wem_stall"}, 32'(wem), 32'(0));
                if (stall_cnt > 0) begin
                    chk({mon_e.name, " per_sel"}, 32'(per_sel), 32'(mon_e.sel));
                    chk({mon_e.name, " per_we"}, 32'(per_we), 32'(mon_e.we));
                    chk({mon_e.name, " per_re"}, 32'(per_re), 32'(mon_e.re));
                    chk({mon_e.name, " per_off"}, 32'(per_off), 32'(mon_e.off));
                    chk({mon_e.name, " per_wdata"}, per_wdata, mon_e.wd);
                end
                stall_cnt++;
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, " stalls"}, 32'(stall_cnt), 32'(mon_e.stalls));
                chk({mon_e.name, " wem"}, 32'(wem), 32'(mon_e.wem));
                chk({mon_e.name, " resp_sel"}, 32'(per_sel), 32'(0));
                chk({mon_e.name, " resp_strobes"}, 32'({per_we, per_re}), 32'(0));
                if (mon_e.is_read) chk({mon_e.name, " rdata"}, rdata, mon_e.rd);
                if (mon_e.chk_err) begin
                    chk({mon_e.name, " bus_err"}, 32'(bus_err), 32'(mon_e.be));
                    chk({mon_e.name, " err_addr"}, err_addr, mon_e.ea);
                end
                stall_cnt = 0;
            end
        end
    end

    // Issue one access at posedge+1 and hold it until the core would advance.
    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] dm, input exp_t e);
        int n;
        mem_write = w; mem_read = r; addr = a; wdata = wd; dmem_rdata = dm;
        sb.push_back(e);
        for (n = 0; n < 64; n++) begin
            @(negedge clk);
            if (!stall) break;
        end
        if (n == 64) begin
            checks++;
            errors++;
            $display("FAIL %s accept: got stall held 64 cycles expected release", e.name);
            void'(sb.pop_front());
        end
        @(posedge clk);
        #1;
        mem_write = 1'b0; mem_read = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst stall", 32'(stall), 32'(0));
        chk("rst per_sel", 32'(per_sel), 32'(0));
        chk("rst strobes", 32'({per_we, per_re}), 32'(0));
        chk("rst per_off", 32'(per_off), 32'(0));
        chk("rst per_wdata", per_wdata, 32'(0));
        chk("rst bus_err", 32'(bus_err), 32'(0));
        chk("rst err_addr", err_addr, 32'(0));
        @(posedge clk);
        #1;

        // Memory-side misses, including both edges of the window and a top-of-space address.
        access(1, 0, 32'd10, 32'h55, 0, mk("st10", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        access(0, 1, 32'd10, 0, 32'h1234, mk("ld10", 1, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        access(0, 1, 32'd59, 0, 32'h5959, mk("ld59", 1, 32'h5959, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        access(1, 0, 32'd76, 32'h76, 0, mk("st76", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        access(0, 1, 32'hFFFF_FFF0, 0, 32'hF0F0, mk("ldtop", 1, 32'hF0F0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Peripheral accesses, back to back.
        ready_slot = 0; ready_at = 0;
        access(1, 0, 32'd61, 32'hCAFE_0061, 0,
               mk("st61", 0, 0, 0, 2, 4'b0001, 1, 0, 2'd1, 32'hCAFE_0061, 0, 0, 0));
        ready_slot = 1; ready_at = 3; noise = 1'b1;
        access(0, 1, 32'd66, 0, 32'h6666,
               mk("ld66", 1, 32'hA5, 0, 4, 4'b0010, 0, 1, 2'd2, 0, 0, 0, 0));
        noise = 1'b0; ready_slot = 0; ready_at = 0;
        access(1, 1, 32'd63, 32'h63, 0,
               mk("rw63", 0, 0, 0, 2, 4'b0001, 1, 0, 2'd3, 32'h63, 0, 0, 0));
        ready_slot = 3;
        access(1, 0, 32'd75, 32'h75, 0,
               mk("st75", 0, 0, 0, 2, 4'b1000, 1, 0, 2'd3, 32'h75, 0, 0, 0));

`ifdef MMIO_TIMEOUT_EN
        ready_at = -1;
        access(0, 1, 32'd70, 0, 32'h7070,
               mk("to70", 1, 32'hDEAD_BEEF, 0, 17, 4'b0100, 0, 1, 2'd2, 0, 1, 1, 32'd70));
        access(0, 1, 32'd71, 0, 32'h7171,
               mk("to71", 1, 32'hDEAD_BEEF, 0, 17, 4'b0100, 0, 1, 2'd3, 0, 1, 1, 32'd70));
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("errclr bus_err", 32'(bus_err), 32'(0));
`else
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("noto bus_err", 32'(bus_err), 32'(0));
        chk("noto err_addr", err_addr, 32'(0));
`endif

        // Reset in the middle of a WAIT with no ready.
        ready_at = -1;
        mem_write = 1'b1; addr = 32'd64; wdata = 32'h77;
        @(posedge clk);
        #1;
        chk("midrst pre stall", 32'(stall), 32'(1));
        chk("midrst pre per_sel", 32'(per_sel), 32'(4'b0010));
        chk("midrst pre per_we", 32'(per_we), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst stall", 32'(stall), 32'(0));
        chk("midrst per_sel", 32'(per_sel), 32'(0));
        chk("midrst per_we", 32'(per_we), 32'(0));
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(1, 0, 32'd5, 32'h5, 0, mk("st5", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clk);
        chk("scoreboard drained", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
